// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge control path.
package bridge_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam int         SLV_IDX_W  = 2;

endpackage

// File: rtl/apb_slave_decoder.sv
// Address/size decode: region hit check and APB slave index from Haddr[27:26].
module apb_slave_decoder
  import bridge_pkg::*;
#(
  parameter logic [3:0] BASE_NIB = 4'h8
) (
  input  logic [5:0]           haddr_hi,  // Haddr[31:26]
  input  logic [2:0]           hsize,
  output logic                 hit,
  output logic [SLV_IDX_W-1:0] idx
);

  assign hit = (haddr_hi[5:2] == BASE_NIB) && (hsize <= HSIZE_WORD);
  assign idx = haddr_hi[1:0];

endmodule

// File: rtl/ahb_apb_xfer_ctrl.sv
// Bridge control FSM: qualifies AHB address phases and sequences APB SETUP/ACCESS,
// inserting AHB wait states and a two-cycle ERROR response for illegal transfers.
module ahb_apb_xfer_ctrl
  import bridge_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         NSLV     = 4,
  parameter logic [3:0] BASE_NIB = 4'h8
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [2:0]        Hsize,
  input  logic              Hreadyin,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [NSLV-1:0]   Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pwrite,
  output logic              Penable,
  output logic [DATA_W-1:0] Pwdata
);

  state_e               state, state_nxt;
  logic                 hit, accept;
  logic [SLV_IDX_W-1:0] idx_dec, idx;

  apb_slave_decoder #(.BASE_NIB(BASE_NIB)) u_dec (
    .haddr_hi (Haddr[31:26]),
    .hsize    (Hsize),
    .hit      (hit),
    .idx      (idx_dec)
  );

  // A new address phase is only taken when the AHB side sees us ready.
  assign accept = Hreadyin
               && (Htrans == TR_NONSEQ || Htrans == TR_SEQ)
               && (state == IDLE || state == ACCESS);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, ACCESS: begin
        if (accept)
          state_nxt = !hit ? ERR1 : (Hwrite ? WWAIT : SETUP);
        else
          state_nxt = IDLE;
      end
      WWAIT:   state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state  <= IDLE;
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        idx    <= idx_dec;
      end
      // Write data arrives in the AHB data phase, one cycle after the address.
      if (state == WWAIT)
        Pwdata <= Hwdata;
    end
  end

  always_comb begin
    Pselx = '0;
    if (state == SETUP || state == ACCESS)
      Pselx = NSLV'(1) << idx;
  end

  assign Penable   = (state == ACCESS);
  assign Hreadyout = !(state == WWAIT || state == SETUP || state == ERR1);
  assign Hresp     = (state == ERR1 || state == ERR2) ? ERROR : OKAY;
  assign Hrdata    = Prdata;

endmodule

// File: doc/ahb_apb_xfer_ctrl.md
Name: ahb_apb_xfer_ctrl

Overview:
- Control FSM for the AHB-to-APB bridge.
- Qualifies AHB address phases, decodes the target among four APB slaves, and sequences the APB SETUP/ACCESS phases.
- Inserts AHB wait states via Hreadyout and returns a two-cycle ERROR response for illegal transfers.
- Sits between the AHB master interface and the APB slave bus; it is the only block driving Pselx, Penable, Hreadyout and Hresp.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSLV, 4, number of APB slaves (width of Pselx).
- BASE_NIB, 4'h8, required value of Haddr[31:28] for a decode hit.

Ports:
- Hclk  in  1  single clock; all state updates on its rising edge.
- Hresetn  in  1  synchronous, active-low reset.
- Htrans  in  2  AHB transfer type.
- Hwrite  in  1  1 = write.
- Hsize  in  3  transfer size.
- Hreadyin  in  1  AHB bus ready.
- Haddr  in  ADDR_W  AHB address.
- Hwdata  in  DATA_W  AHB write data (data phase).
- Prdata  in  DATA_W  APB read data.
- Hreadyout  out  1  bridge ready to the AHB side.
- Hresp  out  2  00 = OKAY, 01 = ERROR.
- Hrdata  out  DATA_W  read data to the AHB side.
- Pselx  out  NSLV  one-hot APB select.
- Paddr  out  ADDR_W  APB address.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB enable.
- Pwdata  out  DATA_W  APB write data.

Behaviour:
- Sync reset (Hresetn=0 at a Hclk edge):
  - state=IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
  - Hreadyout=1, Hresp=00.
  - Reset overrides every transition.
  - Reset mid-transfer aborts the transfer: outputs take reset values on the following cycle and no APB ACCESS completes.
- Transfer qualification:
  - accept = Hreadyin & Htrans[1] & (state is IDLE or ACCESS).
  - Htrans IDLE/BUSY are ignored.
  - While Hreadyin=0 nothing is sampled.
- Decode:
  - hit = (Haddr[31:28]==BASE_NIB) & (Hsize<=3'b010).
  - slave index = Haddr[27:26]; Pselx = one-hot of that index.
- On accept, latch Haddr→Paddr, Hwrite→Pwrite and the slave index. Next state:
  - !hit → ERR1.
  - write → WWAIT.
  - read → SETUP.
- States (Hreadyout and Hresp are decoded from the registered state):
  - IDLE: Pselx=0, Penable=0, Hreadyout=1, Hresp=00.
  - WWAIT: capture Hwdata→Pwdata; Hreadyout=0; → SETUP unconditionally.
  - SETUP: Pselx=one-hot, Penable=0, Hreadyout=0; → ACCESS unconditionally.
  - ACCESS: Pselx held, Penable=1, Hreadyout=1.
    - Completes the AHB data phase.
    - Accepts the next address phase; next state per the accept rules above, else IDLE.
  - ERR1: Hresp=01, Hreadyout=0, no APB activity; → ERR2.
  - ERR2: Hresp=01, Hreadyout=1; → IDLE. No accept in ERR2.
- Hrdata = Prdata combinationally (valid in the read ACCESS cycle).
- Paddr, Pwrite and Pwdata are stable from SETUP through ACCESS.
- Latency:
  - Read: accept at cycle N, SETUP N+1, ACCESS N+2. Back-to-back reads take 2 cycles each.
  - Write: accept N, WWAIT N+1, SETUP N+2, ACCESS N+3. Back-to-back writes take 3 cycles each.
- Penable is never high without Pselx, and never high in two consecutive cycles of the same transfer.
- No PREADY/PSLVERR: ACCESS always lasts exactly one cycle.

Decomposition:
- Package bridge_pkg:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - hresp_e (OKAY=0, ERROR=1).
  - state_e (IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2).
  - HSIZE_WORD=3'b010.
- Sub-module apb_slave_decoder:
  - Combinational Haddr/Hsize → {hit, index}.
  - Instantiated once, reused by the top FSM.

Test Plan:
- Single write: NONSEQ write, Haddr=0x8400_0010, Hwdata=0xDEAD_BEEF.
  - → WWAIT, then Pselx=0010 with Penable=0, then Penable=1.
  - Paddr=0x8400_0010, Pwdata=0xDEAD_BEEF, Pwrite=1.
  - Hreadyout low for exactly 2 cycles.
- Single read: NONSEQ read, Haddr=0x8C00_0004, Prdata=0x1234_5678 driven in ACCESS.
  - → Pselx=1000, Hrdata=0x1234_5678 while Hreadyout=1.
  - 1 wait cycle.
- Back-to-back reads: addresses 0x8000_0000 then 0x8800_0000, the second issued during ACCESS.
  - → Pselx sequence 0001, 0001, 0100, 0100; Penable alternates 0,1,0,1; no IDLE gap.
- Error: write to 0x9000_0000, or Hsize=3'b011 to 0x8000_0000.
  - → Hresp=01 for 2 cycles, Hreadyout 0 then 1, Pselx stays 0.
- Ignored requests: Htrans=BUSY, or NONSEQ with Hreadyin=0.
  - → state stays IDLE, Pselx=0, Hreadyout=1.
- Reset mid-transfer: Hresetn=0 during SETUP of a write.
  - → next cycle Pselx=0, Penable=0, Hreadyout=1, Hresp=00.
  - No ACCESS cycle occurs.
